// File: rtl/debounce_toggle_gen.sv
// debounce_toggle_gen: synchronises a raw push-button level, debounces it
// with a four-state FSM and emits one toggle pulse per accepted press.
// Also reports the debounced level, a busy flag and a wrapping press count.
module debounce_toggle_gen #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             btn_i,
    input  logic             en_i,
    output logic             t_o,
    output logic             btn_level_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] press_cnt_o
);

    localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_HIGH = 2'd1,
        PRESSED   = 2'd2,
        WAIT_LOW  = 2'd3
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   acc_q, acc_d;
    logic                   fire;
    logic                   t_q;
    logic                   btn_level_q;
    logic                   busy_q;
    logic [CNT_W-1:0]       press_cnt_q;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Shift the raw button level through the synchroniser chain.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) sync_q <= '0;
        else         sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
    end

    // FSM state, stable-sample counter and the accept flag.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Next-state logic: a level change must be seen on DEBOUNCE_CYCLES
    // consecutive synced samples before it is accepted.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_bit) begin
                    state_d = WAIT_HIGH;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_HIGH: begin
                if (!sync_bit) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                    acc_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            PRESSED: begin
                if (!sync_bit) begin
                    state_d = WAIT_LOW;
                    cnt_d   = CW'(1);
                end
            end
            WAIT_LOW: begin
                if (sync_bit) begin
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // The pulse trails the accepting transition by one edge so that t_o,
    // btn_level_o and press_cnt_o all change together; en_i is sampled on
    // that edge and a disabled press is simply dropped.
    assign fire = acc_q & en_i;

    // Registered outputs, all derived from the settled FSM state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            t_q         <= 1'b0;
            btn_level_q <= 1'b0;
            busy_q      <= 1'b0;
            press_cnt_q <= '0;
        end else begin
            t_q         <= fire;
            btn_level_q <= (state_q == PRESSED) || (state_q == WAIT_LOW);
            busy_q      <= (state_q == WAIT_HIGH) || (state_q == WAIT_LOW);
            press_cnt_q <= press_cnt_q + CNT_W'(fire);
        end
    end

    assign t_o         = t_q;
    assign btn_level_o = btn_level_q;
    assign busy_o      = busy_q;
    assign press_cnt_o = press_cnt_q;

endmodule
